distance_display_mux: RTL

- Next-generation seven-segment distance display for the radar board.
- Converts an unsigned binary distance to BCD with a sequential double-dabble engine.
- Time-multiplexes NUM_DIGITS digits on the Nexys4 common-anode display, with optional leading-zero blanking and overflow indication.
- Sits between the echo-timing/distance logic and the board display pins.

---
 rtl/distance_display_mux.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/distance_display_mux.sv
// rtl/distance_display_mux.sv - binary distance to BCD (double dabble) with multiplexed seven-segment scan
module distance_display_mux #(
  parameter int DATA_W     = 21,
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     distance,
  input  logic                  valid,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            cathode,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PRE_W = $clog2(SCAN_DIV + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [DATA_W-1:0]  shreg;
  logic [BCD_W-1:0]   work, work_adj, disp;
  logic               ovf_acc;
  logic [CNT_W-1:0]   bit_cnt;
  logic [PRE_W-1:0]   pre;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         sel_nib;
  logic               sel_blank, zero_run;
  logic [6:0]         seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid) state_next = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    work_adj = work;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  // Bits falling out of the top nibble mean the value needs more digits than we have.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      work     <= '0;
      ovf_acc  <= 1'b0;
      bit_cnt  <= '0;
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          shreg   <= distance;
          work    <= '0;
          ovf_acc <= 1'b0;
          bit_cnt <= CNT_W'(DATA_W);
        end
        SHIFT: begin
          {work, shreg} <= {work_adj[BCD_W-2:0], shreg, 1'b0};
          ovf_acc       <= ovf_acc | work_adj[BCD_W-1];
          bit_cnt       <= bit_cnt - 1'b1;
        end
        DONE: begin
          disp     <= work;
          overflow <= ovf_acc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Walk from the most significant digit down so zero_run tracks "all digits at or above i are zero".
  always_comb begin
    zero_run  = 1'b1;
    sel_nib   = 4'd0;
    sel_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) begin
        sel_nib   = disp[4*i +: 4];
        sel_blank = (BLANK_LZ != 0) && (i != 0) && zero_run;
      end
    end
    if (overflow)       seg_next = 7'b0111111;
    else if (sel_blank) seg_next = 7'b1111111;
    else                seg_next = seg_decode(sel_nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode   <= '1;
      cathode <= 7'b1111111;
    end else begin
      anode   <= ~(NUM_DIGITS'(1) << idx);
      cathode <= seg_next;
    end
  end

endmodule
